dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester controller and arbiter in front of the byte-addressed data memory (256 bytes, big-endian, registered read port, write and read choice codes).
- Requester C is the pipeline MEM stage; requester D is the debug/loader port.
- Each request is checked, translated into the memory's write-choice and read-choice codes, and sequenced through the one-cycle memory access.
- The block returns a response and gives the pipeline a stall signal.

Parameters:
MAX_WAIT, 4, number of consecutive lost arbitrations after which D wins over C (legal range 1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
c_req  in  1  C request, held with fields stable until c_gnt seen
c_we  in  1  1=store, 0=load
c_size  in  2  00 word, 01 half, 10 byte, 11 illegal
c_sign  in  1  load sign-extend (half/byte only)
c_addr  in  32  byte address
c_wdata  in  32  store data, right-justified
c_gnt  out  1  one-cycle pulse: C command accepted
c_rvalid  out  1  one-cycle pulse: C access complete
c_rdata  out  32  load data, valid with c_rvalid
c_err  out  1  valid with c_rvalid: access rejected
c_stall  out  1  c_req & ~c_gnt, combinational
d_req, d_we, d_size, d_sign, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err  same as C for requester D
mem_inchoice  out  2  to memory: 00 none, 01 word, 10 half, 11 byte
mem_outchoice  out  3  to memory: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 111 hold
mem_addr  out  32  to memory
mem_wdata  out  32  to memory
mem_rdata  in  32  from memory, registered one cycle after presentation

Behaviour:
- States: IDLE, ACCESS, RESP. Arbitration points are the rising edges that end IDLE and RESP.
- At an arbitration point with any request pending:
  - Latch the winner's command (we, size, sign, addr, wdata, owner, err).
  - Move to ACCESS.
  - Set the winner's gnt to 1 for the ACCESS cycle only.
- At an arbitration point with no request: RESP->IDLE, or stay in IDLE.
- ACCESS always moves to RESP.
- In RESP: owner's rvalid=1; rdata=mem_rdata for loads, 0 for stores or errors; err=latched err.
- Throughput: back-to-back accesses every 2 cycles. Latency from req sampled to rvalid is 2 cycles.
- Error flag is set at latch when any of these hold:
  - addr[31:8]!=0
  - size=11
  - word with addr[1:0]!=0
  - half with addr[0]!=0
- An errored command drives mem_inchoice=00 and mem_outchoice=111 in ACCESS, so no memory effect occurs.
- mem_* outputs are registered.
  - Outside ACCESS: inchoice=00, outchoice=111, addr=0, wdata=0. Memory read data then holds.
  - In ACCESS, store: inchoice from size (01/10/11), outchoice=111.
  - In ACCESS, load: inchoice=00, outchoice from size and sign. Word ignores sign.
- Arbitration: C has fixed priority, except that D wins when starve_cnt>=MAX_WAIT.
- starve_cnt:
  - Increments, saturating, at each arbitration point where d_req=1 and C wins.
  - Clears when D is granted.
  - Unchanged otherwise.
- gnt and rvalid are never high for both requesters in the same cycle.
- Requesters may change fields at the edge ending the gnt cycle. The next sample is at the edge ending RESP.
- Reset (rst_n=0 at an edge):
  - state=IDLE, starve_cnt=0.
  - All gnt/rvalid/err=0, rdata=0.
  - mem_inchoice=00, mem_outchoice=111, mem_addr=0, mem_wdata=0.
  - While rst_n=0, mem_inchoice is combinationally forced to 00, so a store in flight in ACCESS is dropped.
  - No response is issued for an aborted access.
- If c_req and d_req rise in the same cycle with starve_cnt<MAX_WAIT, C wins and D waits.
- A req deasserted without a gnt is a protocol violation. The block behaviour is unspecified, but must not deadlock.

Test Plan:
- Store word C addr=0x10 wdata=0x11223344, then load word C addr=0x10 -> c_gnt 1 cycle after sample, c_rvalid 2 cycles after, c_rdata=0x11223344, c_err=0; memory bytes 0x10..0x13 = 11,22,33,44.
- Load half signed then unsigned at 0x12 after the above store -> 0x00003344 both; byte signed at 0x12 after store byte 0x80 -> 0xFFFFFF80, unsigned -> 0x00000080.
- Misaligned word load addr=0x11, half addr=0x13, addr=0x100, size=11 -> rvalid with err=1, rdata=0, mem_inchoice stays 00 throughout, memory contents unchanged.
- C and D requesting continuously, MAX_WAIT=4 -> grants C,C,C,C,D,C,C,C,C,D...; never both gnt/rvalid together; c_stall=1 exactly in cycles with c_req & ~c_gnt.
- Back-to-back C stores to 0x00,0x04,0x08 -> c_gnt every 2 cycles, 3 rvalid pulses, all data correct on readback.
- rst_n low during ACCESS of store word 0xDEADBEEF to 0x20 -> no rvalid, mem bytes 0x20..0x23 unchanged, all outputs at reset values next cycle, starve_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester front end for the 256-byte big-endian data memory.
// Requester C (pipeline MEM stage) has fixed priority; requester D (debug/loader)
// wins once it has lost MAX_WAIT consecutive arbitrations while requesting.
//
// state  | meaning
// IDLE   | no access in flight; arbitration point at the end of the cycle
// ACCESS | latched command presented to memory; winner's gnt is high
// RESP   | memory read data available; owner's rvalid is high; arbitration point
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_sign,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [1:0]  mem_inchoice,
  output logic [2:0]  mem_outchoice,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             owner_q, owner_d;   // 1 = D owns the current access
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [1:0]       inch_q, inch_d;
  logic [2:0]       outch_q, outch_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      mwdata_q, mwdata_d;

  logic        any_req, d_win;
  logic        sel_we, sel_sign, sel_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  // Winner selection and command checking for the current arbitration point
  always_comb begin
    any_req   = c_req | d_req;
    d_win     = d_req & (~c_req | (starve_q >= MAX_WAIT_C));
    sel_we    = d_win ? d_we    : c_we;
    sel_size  = d_win ? d_size  : c_size;
    sel_sign  = d_win ? d_sign  : c_sign;
    sel_addr  = d_win ? d_addr  : c_addr;
    sel_wdata = d_win ? d_wdata : c_wdata;
    sel_err   = (sel_addr[31:8] != 24'h0) ||
                (sel_size == 2'b11) ||
                ((sel_size == 2'b00) && (sel_addr[1:0] != 2'b00)) ||
                ((sel_size == 2'b01) && sel_addr[0]);
  end

  // Next state, command latch and memory control translation
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    we_d     = we_q;
    err_d    = err_q;
    inch_d   = 2'b00;
    outch_d  = 3'b111;
    maddr_d  = 32'h0;
    mwdata_d = 32'h0;
    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = d_win;
          we_d    = sel_we;
          err_d   = sel_err;
          maddr_d = sel_addr;
          if (sel_we) mwdata_d = sel_wdata;
          // Errored commands leave the memory bus in its idle encoding.
          if (!sel_err) begin
            if (sel_we) begin
              case (sel_size)
                2'b00:   inch_d = 2'b01;
                2'b01:   inch_d = 2'b10;
                2'b10:   inch_d = 2'b11;
                default: inch_d = 2'b00;
              endcase
            end else begin
              case (sel_size)
                2'b00:   outch_d = 3'b000;
                2'b01:   outch_d = sel_sign ? 3'b001 : 3'b010;
                2'b10:   outch_d = sel_sign ? 3'b011 : 3'b100;
                default: outch_d = 3'b111;
              endcase
            end
          end
          if (d_win) begin
            starve_d = '0;
          end else if (d_req && (starve_q != '1)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // State and memory-control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      inch_q   <= 2'b00;
      outch_q  <= 3'b111;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      err_q    <= err_d;
      inch_q   <= inch_d;
      outch_q  <= outch_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // A store caught in ACCESS when reset arrives must not reach the memory.
  assign mem_inchoice  = rst_n ? inch_q : 2'b00;
  assign mem_outchoice = outch_q;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = mwdata_q;

  assign c_gnt    = (state_q == ACCESS) & ~owner_q;
  assign d_gnt    = (state_q == ACCESS) &  owner_q;
  assign c_rvalid = (state_q == RESP) & ~owner_q;
  assign d_rvalid = (state_q == RESP) &  owner_q;
  assign c_err    = c_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;
  assign c_rdata  = (c_rvalid && !we_q && !err_q) ? mem_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && !we_q && !err_q) ? mem_rdata : 32'h0;
  assign c_stall  = c_req & ~c_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-byte big-endian memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, c_sign;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, c_err, c_stall;
  logic [31:0] c_rdata;
  logic        d_req, d_we, d_sign;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [1:0]  mem_inchoice;
  logic [2:0]  mem_outchoice;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic       mem_clr;
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_sign(c_sign),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata), .c_err(c_err), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_inchoice(mem_inchoice), .mem_outchoice(mem_outchoice),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign a0 = mem_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  // Memory model: writes on the edge, registered read port that holds on 111
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 32'h0;
    end else begin
      case (mem_inchoice)
        2'b01: begin
          mem[a0] <= mem_wdata[31:24]; mem[a1] <= mem_wdata[23:16];
          mem[a2] <= mem_wdata[15:8];  mem[a3] <= mem_wdata[7:0];
        end
        2'b10: begin mem[a0] <= mem_wdata[15:8]; mem[a1] <= mem_wdata[7:0]; end
        2'b11: mem[a0] <= mem_wdata[7:0];
        default: ;
      endcase
      case (mem_outchoice)
        3'b000: mem_rdata <= {mem[a0], mem[a1], mem[a2], mem[a3]};
        3'b001: mem_rdata <= {{16{mem[a0][7]}}, mem[a0], mem[a1]};
        3'b010: mem_rdata <= {16'h0, mem[a0], mem[a1]};
        3'b011: mem_rdata <= {{24{mem[a0][7]}}, mem[a0]};
        3'b100: mem_rdata <= {24'h0, mem[a0]};
        default: ;
      endcase
    end
  end

  task automatic drive(input bit is_d, input bit req, input bit we, input logic [1:0] size,
                       input bit sign, input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d) begin
      d_req = req; d_we = we; d_size = size; d_sign = sign; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = req; c_we = we; c_size = size; c_sign = sign; c_addr = addr; c_wdata = wdata;
    end
  endtask

  // Single access from an idle bus: checks latency, memory encoding and response
  task automatic op(input bit is_d, input bit we, input logic [1:0] size, input bit sign,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input bit exp_err,
                    input logic [1:0] exp_in, input logic [2:0] exp_out, input string name);
    int n;
    logic gnt_s, ogn, rv, orv, er;
    logic [31:0] rd;
    @(negedge clk);
    drive(is_d, 1'b1, we, size, sign, addr, wdata);
    n = 0;
    gnt_s = 1'b0;
    while (!gnt_s && n < 8) begin
      @(negedge clk);
      n++;
      gnt_s = is_d ? d_gnt : c_gnt;
    end
    ogn = is_d ? c_gnt : d_gnt;
    checks++;
    if (gnt_s !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL %s gnt latency: got gnt=%b after %0d cycles, want gnt=1 after 1", name, gnt_s, n);
    end
    checks++;
    if (ogn !== 1'b0) begin
      errors++;
      $display("FAIL %s other gnt: got %b want 0", name, ogn);
    end
    checks++;
    if (mem_inchoice !== exp_in || mem_outchoice !== exp_out) begin
      errors++;
      $display("FAIL %s mem choice: got in=%b out=%b want in=%b out=%b",
               name, mem_inchoice, mem_outchoice, exp_in, exp_out);
    end
    if (!exp_err) begin
      checks++;
      if (mem_addr !== addr || mem_wdata !== (we ? wdata : 32'h0)) begin
        errors++;
        $display("FAIL %s mem addr/wdata: got %h/%h want %h/%h", name, mem_addr, mem_wdata,
                 addr, we ? wdata : 32'h0);
      end
    end
    drive(is_d, 1'b0, we, size, sign, addr, wdata);
    @(negedge clk);
    rv  = is_d ? d_rvalid : c_rvalid;
    orv = is_d ? c_rvalid : d_rvalid;
    rd  = is_d ? d_rdata : c_rdata;
    er  = is_d ? d_err : c_err;
    checks++;
    if (rv !== 1'b1 || rd !== exp_rdata || er !== exp_err) begin
      errors++;
      $display("FAIL %s response: got rvalid=%b rdata=%h err=%b want 1 %h %b",
               name, rv, rd, er, exp_rdata, exp_err);
    end
    checks++;
    if (orv !== 1'b0) begin
      errors++;
      $display("FAIL %s other rvalid: got %b want 0", name, orv);
    end
    checks++;
    if (mem_inchoice !== 2'b00 || mem_outchoice !== 3'b111) begin
      errors++;
      $display("FAIL %s idle mem bus: got in=%b out=%b want 00 111", name, mem_inchoice, mem_outchoice);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || c_rvalid !== 1'b0 || d_rvalid !== 1'b0 ||
        c_err !== 1'b0 || d_err !== 1'b0 || c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s handshake outputs: got gnt=%b%b rvalid=%b%b err=%b%b rdata=%h/%h want all 0",
               name, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, c_rdata, d_rdata);
    end
    checks++;
    if (mem_inchoice !== 2'b00 || mem_outchoice !== 3'b111 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s mem outputs: got %b %b %h %h want 00 111 0 0",
               name, mem_inchoice, mem_outchoice, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    checks++;
    if (c_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset stall: got %b want 0", c_stall);
    end
    mem_clr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2'b01, 3'b111, "store word");
    op(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2'b00, 3'b000, "load word");
    checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h11223344) begin
      errors++;
      $display("FAIL word bytes: got %h want 11223344", {mem[16], mem[17], mem[18], mem[19]});
    end
  endtask

  task automatic test_sign();
    op(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00003344, 1'b0, 2'b00, 3'b001, "half signed");
    op(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00003344, 1'b0, 2'b00, 3'b010, "half unsigned");
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h00000080, 32'h0, 1'b0, 2'b11, 3'b111, "store byte");
    op(1'b0, 1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 2'b00, 3'b011, "byte signed");
    op(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h00000080, 1'b0, 2'b00, 3'b100, "byte unsigned");
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h11228044, 1'b0, 2'b00, 3'b000, "D load word");
  endtask

  task automatic test_errors();
    op(1'b0, 1'b0, 2'b00, 1'b0, 32'h11,  32'h0, 32'h0, 1'b1, 2'b00, 3'b111, "err word misaligned");
    op(1'b0, 1'b0, 2'b01, 1'b1, 32'h13,  32'h0, 32'h0, 1'b1, 2'b00, 3'b111, "err half misaligned");
    op(1'b0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 2'b00, 3'b111, "err out of range");
    op(1'b0, 1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 32'h0, 1'b1, 2'b00, 3'b111, "err size 11");
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h11,  32'hAAAAAAAA, 32'h0, 1'b1, 2'b00, 3'b111, "err store misaligned");
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h000000FF, 32'h0, 1'b1, 2'b00, 3'b111, "err store range");
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h11,  32'h0, 32'h0, 1'b1, 2'b00, 3'b111, "D err half");
    checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h11228044 || mem[0] !== 8'h00) begin
      errors++;
      $display("FAIL err memory untouched: got %h / %h want 11228044 / 00",
               {mem[16], mem[17], mem[18], mem[19]}, mem[0]);
    end
  endtask

  // Both requesters held continuously; every fifth grant goes to D
  task automatic test_arbitration(input int n_grants, input string tag);
    bit exp_d, prev_d, exp_stall;
    int g;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0);
    exp_d = 1'b0;
    prev_d = 1'b0;
    for (int i = 1; i <= 2 * n_grants; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        g = (i - 1) / 2;
        exp_d = (g % 5 == 4);
        prev_d = exp_d;
        exp_stall = exp_d;
        checks++;
        if (c_gnt !== ~exp_d || d_gnt !== exp_d || c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL %s grant %0d: got gnt c=%b d=%b rvalid c=%b d=%b want gnt c=%b d=%b rvalid 0",
                   tag, g, c_gnt, d_gnt, c_rvalid, d_rvalid, ~exp_d, exp_d);
        end
      end else begin
        exp_stall = 1'b1;
        checks++;
        if (c_rvalid !== ~prev_d || d_rvalid !== prev_d || c_gnt !== 1'b0 || d_gnt !== 1'b0) begin
          errors++;
          $display("FAIL %s resp cycle %0d: got rvalid c=%b d=%b gnt c=%b d=%b want rvalid c=%b d=%b gnt 0",
                   tag, i, c_rvalid, d_rvalid, c_gnt, d_gnt, ~prev_d, prev_d);
        end
      end
      checks++;
      if (c_stall !== exp_stall) begin
        errors++;
        $display("FAIL %s stall cycle %0d: got %b want %b", tag, i, c_stall, exp_stall);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [3];
    logic [31:0] bd [3];
    int k;
    ba = '{32'h00, 32'h04, 32'h08};
    bd = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, ba[0], bd[0]);
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        checks++;
        if (c_gnt !== 1'b1 || c_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b gnt cycle %0d: got gnt=%b rvalid=%b want 1 0", i, c_gnt, c_rvalid);
        end
        k++;
        if (k < 3) drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, ba[k], bd[k]);
        else       drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, ba[2], bd[2]);
      end else begin
        checks++;
        if (c_rvalid !== 1'b1 || c_gnt !== 1'b0 || c_err !== 1'b0 || c_rdata !== 32'h0) begin
          errors++;
          $display("FAIL b2b resp cycle %0d: got rvalid=%b gnt=%b err=%b rdata=%h want 1 0 0 0",
                   i, c_rvalid, c_gnt, c_err, c_rdata);
        end
      end
    end
    for (int j = 0; j < 3; j++)
      op(1'b0, 1'b0, 2'b00, 1'b0, ba[j], 32'h0, bd[j], 1'b0, 2'b00, 3'b000, "b2b readback");
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0);
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || mem_inchoice !== 2'b01) begin
      errors++;
      $display("FAIL rst setup: got gnt=%b inchoice=%b want 1 01", c_gnt, mem_inchoice);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0);
    #1;
    checks++;
    if (mem_inchoice !== 2'b00) begin
      errors++;
      $display("FAIL rst forces inchoice: got %b want 00", mem_inchoice);
    end
    @(negedge clk);
    check_reset_outputs("rst in access");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst no response: got rvalid c=%b d=%b want 0 0", c_rvalid, d_rvalid);
    end
    checks++;
    if ({mem[32], mem[33], mem[34], mem[35]} !== 32'h0) begin
      errors++;
      $display("FAIL rst dropped store: got %h want 00000000", {mem[32], mem[33], mem[34], mem[35]});
    end
    // A starvation count surviving reset would hand D the fourth grant.
    test_arbitration(5, "post-reset arb");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_sign();
    test_errors();
    test_arbitration(10, "arb");
    test_back_to_back();
    test_reset_in_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
